// File: rtl/fifo_flex.sv
// fifo_flex: single-clock FIFO with full-range count, programmable thresholds, flush and sticky error flags
// Ports: clk/rst (sync, active-high); data_in/wr_en push; rd_en pop; flush clears contents;
//   clr_err clears overflow/underflow; data_out read data; empty/full/almost_empty/almost_full
//   status; cnt stored words 0..depth; overflow/underflow sticky rejection flags.
// Build option: FIFO_FWFT_EN selects first-word-fall-through data_out instead of registered read.
module fifo_flex #(
  parameter int data_width = 8,
  parameter int addr_width = 8,
  parameter int af_margin  = 4,
  parameter int ae_margin  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [data_width-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic                  flush,
  input  logic                  clr_err,
  output logic [data_width-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [addr_width:0]   cnt,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int depth = 1 << addr_width;
  localparam logic [addr_width:0] c_full = (addr_width+1)'(depth);
  localparam logic [addr_width:0] c_af = (addr_width+1)'(depth - af_margin);
  localparam logic [addr_width:0] c_ae = (addr_width+1)'(ae_margin);
  logic [data_width-1:0] r_mem [depth];
  logic [addr_width-1:0] r_wr_ptr, r_rd_ptr;
  logic [addr_width:0]   r_cnt, w_cnt_nxt;
  logic r_empty, r_full, r_ae, r_af, r_ovf, r_unf;
  logic w_rd, w_wr;
  assign w_rd = rd_en && !r_empty;
  assign w_wr = wr_en && (!r_full || w_rd);
  always_comb w_cnt_nxt = (rst || flush) ? '0 :
                          (w_wr && !w_rd) ? r_cnt + (addr_width+1)'(1) :
                          (!w_wr && w_rd) ? r_cnt - (addr_width+1)'(1) : r_cnt;
  // Status flags are registered from the next count so they move on the same edge as cnt.
  always_ff @(posedge clk) begin
    r_cnt   <= w_cnt_nxt;
    r_empty <= w_cnt_nxt == '0;
    r_full  <= w_cnt_nxt == c_full;
    r_af    <= w_cnt_nxt >= c_af;
    r_ae    <= w_cnt_nxt <= c_ae;
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + addr_width'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + addr_width'(1);
    end
  end
  // A new rejection in the same cycle as clr_err wins; flush leaves the flags alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (!flush) begin
      r_ovf <= (wr_en && !w_wr) || (r_ovf && !clr_err);
      r_unf <= (rd_en && r_empty) || (r_unf && !clr_err);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && !flush && w_wr) r_mem[r_wr_ptr] <= data_in;
  end
`ifdef FIFO_FWFT_EN
  assign data_out = r_mem[r_rd_ptr];
`else
  logic [data_width-1:0] r_dout;
  always_ff @(posedge clk) begin
    if (rst) r_dout <= '0;
    else if (!flush && w_rd) r_dout <= r_mem[r_rd_ptr];
  end
  assign data_out = r_dout;
`endif
  assign empty        = r_empty;
  assign full         = r_full;
  assign almost_empty = r_ae;
  assign almost_full  = r_af;
  assign cnt          = r_cnt;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;
endmodule

// File: tb/tb_fifo_flex.sv
// tb_fifo_flex: directed self-checking bench for fifo_flex (depth 8, af_margin 2, ae_margin 1)
module tb_fifo_flex;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_in = '0;
  logic       wr_en = 1'b0, rd_en = 1'b0, flush = 1'b0, clr_err = 1'b0;
  logic [7:0] data_out;
  logic       empty, full, almost_empty, almost_full, overflow, underflow;
  logic [3:0] cnt;
  int n_tests = 0;
  int n_fail = 0;
  fifo_flex #(.data_width(8), .addr_width(3), .af_margin(2), .ae_margin(1)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .flush(flush), .clr_err(clr_err), .data_out(data_out), .empty(empty),
    .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
    .cnt(cnt), .overflow(overflow), .underflow(underflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic w, input logic r, input logic fl, input logic ce, input logic rs, input logic [7:0] d);
    wr_en = w; rd_en = r; flush = fl; clr_err = ce; rst = rs; data_in = d;
    @(posedge clk); #1;
    wr_en = 0; rd_en = 0; flush = 0; clr_err = 0; rst = 0; data_in = '0;
  endtask
  task automatic op(input logic w, input logic r, input logic [7:0] d, input logic chkd, input logic [7:0] exp);
`ifdef FIFO_FWFT_EN
    if (chkd) chk("dout_fwft", data_out, exp);
    cyc(w, r, 0, 0, 0, d);
`else
    cyc(w, r, 0, 0, 0, d);
    if (chkd) chk("dout", data_out, exp);
`endif
  endtask
  task automatic flags(input string tag, input int c, input logic e, input logic f, input logic ae, input logic af);
    chk({tag, "_cnt"}, cnt, c);
    chk({tag, "_empty"}, empty, e);
    chk({tag, "_full"}, full, f);
    chk({tag, "_ae"}, almost_empty, ae);
    chk({tag, "_af"}, almost_full, af);
  endtask
  initial begin
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    flags("rst", 0, 1, 0, 1, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
`ifndef FIFO_FWFT_EN
    chk("rst_dout", data_out, 0);
`endif
    for (int k = 1; k <= 8; k++) begin
      cyc(1, 0, 0, 0, 0, 8'(k));
      flags("push", k, 0, k == 8, k <= 1, k >= 6);
    end
    cyc(1, 0, 0, 0, 0, 9);
    flags("push9", 8, 0, 1, 0, 1);
    chk("ovf_set", overflow, 1);
    for (int k = 1; k <= 8; k++) begin
      op(0, 1, 0, 1, 8'(k));
      chk("pop_cnt", cnt, 8 - k);
    end
    flags("drained", 0, 1, 0, 1, 0);
    chk("drained_unf", underflow, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("unf_set", underflow, 1);
    chk("unf_cnt", cnt, 0);
`ifndef FIFO_FWFT_EN
    chk("unf_dout_hold", data_out, 8);
`endif
    cyc(0, 0, 0, 1, 0, 0);
    chk("clr_unf", underflow, 0);
    chk("clr_ovf", overflow, 0);
    cyc(0, 1, 0, 1, 0, 0);
    chk("clr_vs_new_unf", underflow, 1);
    cyc(0, 0, 0, 1, 0, 0);
    chk("clr_unf2", underflow, 0);
    for (int k = 0; k < 8; k++) cyc(1, 0, 0, 0, 0, 8'(10 + k));
    flags("refill", 8, 0, 1, 0, 1);
    op(1, 1, 50, 1, 10);
    flags("full_rw", 8, 0, 1, 0, 1);
    chk("full_rw_ovf", overflow, 0);
    for (int k = 0; k < 7; k++) op(0, 1, 0, 1, 8'(11 + k));
    op(0, 1, 0, 1, 50);
    flags("drain2", 0, 1, 0, 1, 0);
    cyc(1, 1, 0, 0, 0, 7);
    flags("empty_rw", 1, 0, 0, 1, 0);
    chk("empty_rw_unf", underflow, 1);
    op(0, 1, 0, 1, 7);
    chk("empty_rw_cnt", cnt, 0);
    cyc(0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) cyc(1, 0, 0, 0, 0, 8'(100 + k));
    for (int i = 0; i < 20; i++) begin
      op(1, 1, 8'(103 + i), 1, 8'(100 + i));
      chk("wrap_cnt", cnt, 3);
    end
    cyc(1, 0, 0, 0, 0, 60);
    cyc(1, 0, 0, 0, 0, 61);
    chk("pre_flush_cnt", cnt, 5);
    cyc(1, 0, 1, 0, 0, 99);
    flags("flush", 0, 1, 0, 1, 0);
`ifndef FIFO_FWFT_EN
    chk("flush_dout_hold", data_out, 119);
`endif
    chk("flush_ovf", overflow, 0);
    chk("flush_unf", underflow, 0);
    cyc(1, 0, 0, 0, 0, 33);
    chk("post_flush_cnt", cnt, 1);
`ifdef FIFO_FWFT_EN
    chk("fwft_fall", data_out, 33);
`endif
    op(0, 1, 0, 1, 33);
    flags("post_flush", 0, 1, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 5);
    cyc(1, 0, 0, 0, 0, 6);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("pre_rst_unf", underflow, 1);
    cyc(1, 0, 0, 0, 0, 44);
    cyc(1, 1, 0, 0, 1, 45);
    flags("mid_rst", 0, 1, 0, 1, 0);
    chk("mid_rst_unf", underflow, 0);
`ifndef FIFO_FWFT_EN
    chk("mid_rst_dout", data_out, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
